csa_resolver: RTL and testbench

CSA_RESOLVER -- requirements
Module: csa_resolver

---
 rtl/csa_pkg.sv | 15 +
 rtl/csa_resolver_stage.sv | 47 ++++
 rtl/csa_resolver.sv | 94 +++++++++
 tb/tb_csa_resolver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared defaults and the per-stage record passed along the csa_resolver pipeline.
package csa_pkg;

    localparam int CSA_WIDTH = 32;
    localparam int CSA_SEG   = 8;

    typedef struct packed {
        logic                 valid;
        logic [CSA_WIDTH-1:0] res;
        logic                 cy;
        logic [CSA_WIDTH-1:0] psum;
        logic [CSA_WIDTH-1:0] pcarry;
    } csa_stage_t;

endpackage

// File: rtl/csa_resolver_stage.sv
// One SEG-bit slice of the carry-save resolver: adds segment K plus the incoming carry,
// and forwards the still-unresolved sum/carry vectors unchanged.
module csa_resolver_stage
    import csa_pkg::*;
#(
    parameter int SEG  = CSA_SEG,
    parameter int K    = 0,
    parameter bit LAST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  csa_stage_t stg_p0,
    output csa_stage_t stg_p1
);

    localparam int LO = K * SEG;

    logic [SEG:0]       seg_sum;
    logic [CSA_WIDTH-1:0] res_nxt;

    always_comb begin
        seg_sum = {1'b0, stg_p0.psum[LO +: SEG]}
                + {1'b0, stg_p0.pcarry[LO +: SEG]}
                + {{SEG{1'b0}}, stg_p0.cy};
        res_nxt = stg_p0.res;
        res_nxt[LO +: SEG] = seg_sum[SEG-1:0];
    end

    // stage boundary: only the last stage's data is visible, so only it is cleared
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_p1.valid <= 1'b0;
            if (LAST) begin
                stg_p1.res <= '0;
                stg_p1.cy  <= 1'b0;
            end
        end else if (advance) begin
            stg_p1.valid  <= stg_p0.valid;
            stg_p1.res    <= res_nxt;
            stg_p1.cy     <= seg_sum[SEG];
            stg_p1.psum   <= stg_p0.psum;
            stg_p1.pcarry <= stg_p0.pcarry;
        end
    end

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save sum/carry pair into a binary result with valid/ready handshakes.
// Define CSA_RESOLVER_PIPE_EN for the NSEG-stage pipeline; otherwise a single registered adder.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int SEG   = CSA_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout
);

    // The stage record is sized by the package default, so WIDTH may not exceed it.
    if ((WIDTH % SEG) != 0 || WIDTH > CSA_WIDTH) begin : g_bad_cfg
        $error("csa_resolver: WIDTH must be a multiple of SEG and at most CSA_WIDTH");
    end

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

`ifdef CSA_RESOLVER_PIPE_EN
    localparam int NSEG = WIDTH / SEG;

    csa_stage_t stg_in;
    csa_stage_t stg [NSEG];

    always_comb begin
        stg_in        = '0;
        stg_in.valid  = in_valid;
        stg_in.psum   = CSA_WIDTH'(in_sum);
        stg_in.pcarry = CSA_WIDTH'(in_carry);
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        if (k == 0) begin : g_first
            csa_resolver_stage #(
                .SEG  (SEG),
                .K    (k),
                .LAST (NSEG == 1)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .advance (advance),
                .stg_p0  (stg_in),
                .stg_p1  (stg[k])
            );
        end else begin : g_next
            csa_resolver_stage #(
                .SEG  (SEG),
                .K    (k),
                .LAST (k == NSEG - 1)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .advance (advance),
                .stg_p0  (stg[k-1]),
                .stg_p1  (stg[k])
            );
        end
    end

    assign out_valid = stg[NSEG-1].valid;
    assign out_data  = stg[NSEG-1].res[WIDTH-1:0];
    assign out_cout  = stg[NSEG-1].cy;
`else
    logic [WIDTH:0] sum_p0;

    always_comb sum_p0 = {1'b0, in_sum} + {1'b0, in_carry};

    // single output register boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cout  <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_data  <= sum_p0[WIDTH-1:0];
            out_cout  <= sum_p0[WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: queue-based reference model plus directed literal checks.
module tb_csa_resolver;

    localparam int W = 32;
`ifdef CSA_RESOLVER_PIPE_EN
    localparam int LAT = W / 8;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sum;
    logic [W-1:0] in_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_cout;

    always #5 clk = ~clk;

    csa_resolver #(.WIDTH(W), .SEG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cout  (out_cout)
    );

    typedef struct {
        logic [W:0] val;
        int         acc;
    } item_t;

    item_t      q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_in     = 0;
    int         n_out    = 0;
    bit         lat_chk  = 1'b0;
    bit         hold_pend = 1'b0;
    logic [W:0] hold_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every accepted pair must come out, in order, as the 33-bit sum.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            hold_pend = 1'b0;
        end else begin
            chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
            if (hold_pend) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_data", {31'd0, out_cout, out_data}, {31'd0, hold_val});
            end
            if (out_valid && out_ready) begin
                item_t it;
                if (q.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    it = q.pop_front();
                    chk("result", {31'd0, out_cout, out_data}, {31'd0, it.val});
                    if (lat_chk) chk("latency", 64'(cyc - it.acc), 64'(LAT));
                end
                n_out++;
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = {out_cout, out_data};
            if (in_valid && in_ready) begin
                item_t ni;
                ni.val = {1'b0, in_sum} + {1'b0, in_carry};
                ni.acc = cyc;
                q.push_back(ni);
                n_in++;
            end
        end
    end

    task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
        int n = 0;
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [W:0] exp);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk({name, "_timeout"}, 64'd0, 64'd1);
        else chk(name, {31'd0, out_cout, out_data}, {31'd0, exp});
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom % 8)
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h00FF_00FF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n0;
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_cout", {63'd0, out_cout}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        rst_n     = 1'b1;
        out_ready = 1'b1;
        lat_chk   = 1'b1;

        // all-ones plus one wraps to zero with carry out
        fork
            send(32'hFFFF_FFFF, 32'h0000_0001);
            expect_out("wrap_to_zero", 33'h1_0000_0000);
        join
        repeat (3) @(posedge clk);
        #1;

        // back-to-back items emerge on consecutive cycles
        fork
            begin
                send(32'd1, 32'd2);
                send(32'd3, 32'd4);
                send(32'h8000_0000, 32'h8000_0000);
            end
            begin
                expect_out("b2b_first", 33'd3);
                expect_out("b2b_second", 33'd7);
                expect_out("b2b_third", 33'h1_0000_0000);
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // stalled consumer: pipe fills, in_ready drops, nothing is lost
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        n0        = n_out;
        fork
            for (int i = 0; i < 6; i++) send(32'hF000_0000 + i, 32'h1000_0000 * i + 32'h0000_00FF);
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("stall_in_ready_low", {63'd0, in_ready}, 64'd0);
                chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
                out_ready = 1'b1;
            end
        join
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("stall_count", 64'(n_out - n0), 64'd6);
        chk("stall_queue_empty", 64'(q.size()), 64'd0);

        // reset with items in flight discards all of them
        out_ready = 1'b0;
        for (int i = 0; i < ((LAT < 3) ? LAT : 3); i++) send(32'h1234_0000 + i, 32'h0000_4321);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_out_data", {32'd0, out_data}, 64'd0);
        out_ready = 1'b1;
        n0 = n_out;
        repeat (LAT + 6) @(posedge clk);
        #1;
        chk("midrst_no_stale", 64'(n_out - n0), 64'd0);

        // randomized traffic against the model
        n0    = n_in;
        guard = 0;
        while ((n_in - n0) < 10000 && guard < 60000) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            in_sum    = rnd_word();
            in_carry  = rnd_word();
            @(posedge clk);
            #1;
            guard++;
        end
        chk("random_budget", {63'd0, ((n_in - n0) >= 10000)}, 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
